// File: rtl/lcd_text_buf.sv
// lcd_text_buf: character frame buffer between the key decoder and the LCD
// command sequencer.
//  - Accepts ASCII bytes on valid_i/recv_data/ready_o.
//    08 = backspace, 0D = carriage return, 0C = form feed (deferred clear).
//  - After UPDATE_PERIOD+1 idle cycles it streams every entry, index 0 upward,
//    on char/valid_o/ready_i. frame_last_o marks index DEPTH-1.
//  - wr_ptr_o exposes the cursor.
// Optional: define LCD_TEXT_BUF_DIRTY_REFRESH_EN to skip scans when nothing
// has changed since the previous scan.
// Ports: CLK, RST (async, active low), valid_i, recv_data[7:0], ready_o,
//        char[7:0], valid_o, ready_i, frame_last_o, wr_ptr_o[DEPTH_LOG2-1:0]
module lcd_text_buf #(
  parameter int          DEPTH_LOG2    = 5,
  parameter logic [31:0] UPDATE_PERIOD = 32'd240_000_000,
  parameter logic [7:0]  FILL_CHAR     = 8'h20
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  valid_i,
  input  logic [7:0]            recv_data,
  output logic                  ready_o,
  output logic [7:0]            char,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_last_o,
  output logic [DEPTH_LOG2-1:0] wr_ptr_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2-1:0] idx_t;
  localparam idx_t LAST = idx_t'(DEPTH - 1);
  localparam idx_t ONE  = idx_t'(1);
  localparam logic [7:0] BS = 8'h08, CR = 8'h0D, FF = 8'h0C;

  typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;
  state_t state_q, state_d;

  logic [7:0]  mem [DEPTH];
  idx_t        wr_ptr, rd_idx;
  logic [31:0] cnt_wait;
  logic        clear_pend;
  logic        acc, ff_acc, thresh, scan_ok;

  assign ready_o  = (state_q != CLEAR) && !clear_pend;
  assign acc      = valid_i && ready_o;
  assign ff_acc   = acc && (recv_data == FF);
  assign thresh   = (state_q == IDLE) && (cnt_wait >= UPDATE_PERIOD);
  assign wr_ptr_o = wr_ptr;

`ifdef LCD_TEXT_BUF_DIRTY_REFRESH_EN
  // Set by anything that changes the visible contents; consumed by a scan.
  logic dirty;
  assign scan_ok = dirty;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      dirty <= 1'b1;
    else if (state_q == IDLE && state_d == SCAN)
      dirty <= 1'b0;
    else if ((state_q == CLEAR && rd_idx == LAST) ||
             (acc && recv_data != CR && recv_data != FF))
      dirty <= 1'b1;
  end
`else
  assign scan_ok = 1'b1;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    valid_o      = 1'b0;
    char         = FILL_CHAR;
    frame_last_o = 1'b0;
    case (state_q)
      IDLE: begin
        // A form feed beats a scan starting on the same cycle.
        if (ff_acc)                 state_d = CLEAR;
        else if (thresh && scan_ok) state_d = SCAN;
      end
      SCAN: begin
        valid_o      = 1'b1;
        char         = mem[rd_idx];
        frame_last_o = (rd_idx == LAST);
        if (ready_i && rd_idx == LAST)
          state_d = (clear_pend || ff_acc) ? CLEAR : IDLE;
      end
      CLEAR: if (rd_idx == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_CHAR;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      cnt_wait   <= '0;
      clear_pend <= 1'b0;
    end else begin
      // Counts only while idle; zero on the threshold (scan or not) and on
      // any exit, so every state is re-entered with a fresh count.
      if (state_q == IDLE && !thresh && !ff_acc) cnt_wait <= cnt_wait + 32'd1;
      else                                       cnt_wait <= '0;

      // rd_idx doubles as the clear index; it wraps to 0 at scan end.
      case (state_q)
        SCAN:    if (ready_i) rd_idx <= rd_idx + ONE;
        CLEAR:   rd_idx <= rd_idx + ONE;
        default: rd_idx <= '0;
      endcase

      if (state_q == CLEAR) begin
        mem[rd_idx] <= FILL_CHAR;
        if (rd_idx == LAST) begin
          wr_ptr     <= '0;
          clear_pend <= 1'b0;
        end
      end else if (acc) begin
        case (recv_data)
          BS: begin
            // Cursor saturates at 0; entry 0 is still blanked.
            if (wr_ptr != '0) begin
              mem[wr_ptr - ONE] <= FILL_CHAR;
              wr_ptr            <= wr_ptr - ONE;
            end else begin
              mem[0] <= FILL_CHAR;
            end
          end
          CR: wr_ptr <= '0;
          FF: if (state_q == SCAN) clear_pend <= 1'b1;
          default: begin
            mem[wr_ptr] <= recv_data;
            wr_ptr      <= wr_ptr + ONE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lcd_text_buf.sv
// Directed bench for lcd_text_buf with DEPTH_LOG2=2, UPDATE_PERIOD=10.
// Inputs change and outputs are sampled on the falling edge.
module tb_lcd_text_buf;
  logic       CLK = 1'b0, RST = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic [7:0] recv_data = 8'h00;
  logic       ready_o, valid_o, frame_last_o;
  logic [7:0] char;
  logic [1:0] wr_ptr_o;
  int n_cmp = 0, n_err = 0;

  lcd_text_buf #(.DEPTH_LOG2(2), .UPDATE_PERIOD(32'd10), .FILL_CHAR(8'h20)) dut (
    .CLK(CLK), .RST(RST), .valid_i(valid_i), .recv_data(recv_data),
    .ready_o(ready_o), .char(char), .valid_o(valid_o), .ready_i(ready_i),
    .frame_last_o(frame_last_o), .wr_ptr_o(wr_ptr_o)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic send(input logic [7:0] b);
    int g = 0;
    valid_i = 1'b1; recv_data = b;
    while (!ready_o && g < 100) begin tick(); g++; end
    tick();
    valid_i = 1'b0;
  endtask

  // Waits (bounded) for valid_o; n returns cycles waited.
  task automatic wait_valid(output int n, output bit to);
    n = 0;
    while (!valid_o && n < 200) begin tick(); n++; end
    to = !valid_o;
  endtask

  // Captures one full scan; c[0] is index 0.
  task automatic grab_scan(output logic [3:0][7:0] c, output logic [3:0] fl, output bit to);
    int k = 0, g = 0;
    c = '0; fl = '0;
    while (!valid_o && g < 200) begin tick(); g++; end
    while (k < 4 && g < 400) begin
      if (valid_o && ready_i) begin c[k] = char; fl[k] = frame_last_o; k++; end
      tick(); g++;
    end
    to = (k < 4);
  endtask

  task automatic test_reset;
    int n; bit to; logic [3:0][7:0] c; logic [3:0] fl;
    RST = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({valid_o, ready_o, frame_last_o} !== 3'b010) begin n_err++;
      $display("FAIL reset_flags: got v/r/fl=%b want 010", {valid_o, ready_o, frame_last_o}); end
    n_cmp++; if (char !== 8'h20) begin n_err++; $display("FAIL reset_char: got %h want 20", char); end
    n_cmp++; if (wr_ptr_o !== 2'd0) begin n_err++; $display("FAIL reset_wr_ptr: got %0d want 0", wr_ptr_o); end
    RST = 1'b1;
    wait_valid(n, to);
    n_cmp++; if (n !== 11 || to) begin n_err++; $display("FAIL first_scan_cycle: got %0d want 11", n); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {4{8'h20}} || to) begin n_err++; $display("FAIL reset_scan: got %h want 20202020", c); end
    n_cmp++; if (fl !== 4'b1000) begin n_err++; $display("FAIL reset_frame_last: got %b want 1000", fl); end
`ifndef LCD_TEXT_BUF_DIRTY_REFRESH_EN
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL scan_end_valid: got %b want 0", valid_o); end
    wait_valid(n, to);
    n_cmp++; if (n !== 11 || to) begin n_err++; $display("FAIL idle_gap: got %0d want 11", n); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {4{8'h20}} || to) begin n_err++; $display("FAIL repeat_scan: got %h want 20202020", c); end
`endif
  endtask

  task automatic test_wrap;
    bit to; logic [3:0][7:0] c; logic [3:0] fl;
    send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45);
    n_cmp++; if (wr_ptr_o !== 2'd1) begin n_err++; $display("FAIL wrap_wr_ptr: got %0d want 1", wr_ptr_o); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {8'h44, 8'h43, 8'h42, 8'h45} || to) begin n_err++;
      $display("FAIL wrap_scan: got %h want 44434245", c); end
    n_cmp++; if (fl !== 4'b1000) begin n_err++; $display("FAIL wrap_frame_last: got %b want 1000", fl); end
  endtask

  task automatic test_backspace;
    bit to; logic [3:0][7:0] c; logic [3:0] fl;
    RST = 1'b0; tick(); RST = 1'b1;
    send(8'h41); send(8'h42); send(8'h08); send(8'h08); send(8'h08);
    n_cmp++; if (wr_ptr_o !== 2'd0) begin n_err++; $display("FAIL bs_wr_ptr: got %0d want 0", wr_ptr_o); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {4{8'h20}} || to) begin n_err++; $display("FAIL bs_scan: got %h want 20202020", c); end
    send(8'h0D); send(8'h5A);
    n_cmp++; if (wr_ptr_o !== 2'd1) begin n_err++; $display("FAIL cr_wr_ptr: got %0d want 1", wr_ptr_o); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {8'h20, 8'h20, 8'h20, 8'h5A} || to) begin n_err++;
      $display("FAIL cr_scan: got %h want 2020205a", c); end
  endtask

  task automatic test_stall;
    int n; bit to; logic [2:0][7:0] ex;
    ex = {8'h44, 8'h43, 8'h42};
    send(8'h0D); send(8'h41); send(8'h42); send(8'h43); send(8'h44);
    n_cmp++; if (wr_ptr_o !== 2'd0) begin n_err++; $display("FAIL fill_wr_ptr: got %0d want 0", wr_ptr_o); end
    wait_valid(n, to);
    n_cmp++; if (char !== 8'h41 || to) begin n_err++; $display("FAIL stall_idx0: got %h want 41", char); end
    tick();
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (valid_o !== 1'b1 || char !== 8'h42) begin n_err++;
        $display("FAIL stall_hold%0d: got v=%b c=%h want v=1 c=42", i, valid_o, char); end
      tick();
    end
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (valid_o !== 1'b1 || char !== ex[k]) begin n_err++;
        $display("FAIL stall_resume%0d: got v=%b c=%h want v=1 c=%h", k, valid_o, char, ex[k]); end
      n_cmp++; if (frame_last_o !== (k == 2)) begin n_err++;
        $display("FAIL stall_frame_last%0d: got %b want %b", k, frame_last_o, k == 2); end
      tick();
    end
    n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL stall_end: got v=%b want 0", valid_o); end
  endtask

  task automatic test_form_feed;
    int n; bit to; logic [3:0][7:0] c; logic [3:0] fl; logic [2:0][7:0] ex;
    ex = {8'h44, 8'h43, 8'h42};
    wait_valid(n, to);
    n_cmp++; if (char !== 8'h41 || to) begin n_err++; $display("FAIL ff_idx0: got %h want 41", char); end
    valid_i = 1'b1; recv_data = 8'h0C;
    tick();
    valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (ready_o !== 1'b0 || char !== ex[k]) begin n_err++;
        $display("FAIL ff_scan%0d: got r=%b c=%h want r=0 c=%h", k, ready_o, char, ex[k]); end
      tick();
    end
    n = 0;
    while (!ready_o && n < 50) begin
      if (valid_o !== 1'b0) begin n_cmp++; n_err++; $display("FAIL clear_valid: got %b want 0", valid_o); end
      tick(); n++;
    end
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL clear_len: got %0d want 4", n); end
    n_cmp++; if (wr_ptr_o !== 2'd0) begin n_err++; $display("FAIL clear_wr_ptr: got %0d want 0", wr_ptr_o); end
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {4{8'h20}} || to) begin n_err++; $display("FAIL clear_scan: got %h want 20202020", c); end
  endtask

  task automatic test_reset_abort;
    int n; bit to;
    send(8'h51);
    wait_valid(n, to);
    tick();
    RST = 1'b0;
    #1;
    n_cmp++; if ({valid_o, ready_o, frame_last_o} !== 3'b010 || char !== 8'h20 || to) begin n_err++;
      $display("FAIL abort_outputs: got v/r/fl=%b c=%h want 010 c=20", {valid_o, ready_o, frame_last_o}, char); end
    n_cmp++; if (wr_ptr_o !== 2'd0) begin n_err++; $display("FAIL abort_wr_ptr: got %0d want 0", wr_ptr_o); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

`ifdef LCD_TEXT_BUF_DIRTY_REFRESH_EN
  task automatic test_dirty;
    int n; bit to; logic [3:0][7:0] c; logic [3:0] fl; bit seen;
    RST = 1'b0; tick(); RST = 1'b1;
    grab_scan(c, fl, to);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin seen |= valid_o; tick(); end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL dirty_no_scan: got scan=%b want 0", seen); end
    send(8'h41);
    grab_scan(c, fl, to);
    n_cmp++; if (c !== {8'h20, 8'h20, 8'h20, 8'h41} || to) begin n_err++;
      $display("FAIL dirty_scan: got %h want 20202041", c); end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_backspace();
    test_stall();
    test_form_feed();
    test_reset_abort();
`ifdef LCD_TEXT_BUF_DIRTY_REFRESH_EN
    test_dirty();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
